// File: rtl/seq_recorder.sv
// rtl/seq_recorder.sv - records a step-word stream into one sequence RAM slot and
// terminates it with a marker word (bit DATA_W-1 set, low bits = step count).
module seq_recorder #(
  parameter int SEQ_W  = 6,
  parameter int SLOT_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                    CLK_50,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SEQ_W-1:0]        seq_num,
  input  logic                    step_valid,
  input  logic [DATA_W-1:0]       step_data,
  output logic                    step_ready,
  input  logic                    commit,
  input  logic                    abort,
  output logic [SEQ_W+SLOT_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0]       ram_data,
  output logic                    ram_wren,
  output logic                    busy,
  output logic                    done,
  output logic [SLOT_W-1:0]       step_count,
  output logic                    overflow
);

  localparam logic [SLOT_W-1:0] MAX_STEPS    = {SLOT_W{1'b1}};
  localparam logic [SLOT_W-1:0] MAX_STEPS_M1 = MAX_STEPS - 1'b1;
  localparam logic [DATA_W-1:0] STEP_MASK    = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECORD,
    S_TERM,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [SEQ_W-1:0]          slot_q, slot_d;
  logic [SLOT_W-1:0]         idx_q, idx_d;
  logic [SLOT_W-1:0]         step_count_q, step_count_d;
  logic                      step_ready_q, step_ready_d;
  logic                      ram_wren_q, ram_wren_d;
  logic [SEQ_W+SLOT_W-1:0]   ram_wraddress_q, ram_wraddress_d;
  logic [DATA_W-1:0]         ram_data_q, ram_data_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      overflow_q, overflow_d;
  logic                      accept;

  always_comb begin
    state_d         = state_q;
    slot_d          = slot_q;
    idx_d           = idx_q;
    step_count_d    = step_count_q;
    ram_wren_d      = 1'b0;
    ram_wraddress_d = ram_wraddress_q;
    ram_data_d      = ram_data_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    overflow_d      = overflow_q;
    accept          = step_valid && step_ready_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          slot_d       = seq_num;
          idx_d        = '0;
          step_count_d = '0;
          overflow_d   = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_RECORD;
        end
      end

      S_RECORD: begin
        if (step_valid && (idx_q == MAX_STEPS)) begin
          overflow_d = 1'b1;
        end
        // abort outranks both a coincident step and a coincident commit
        if (abort) begin
          idx_d        = '0;
          step_count_d = '0;
          state_d      = S_TERM;
        end else begin
          if (accept) begin
            ram_wren_d      = 1'b1;
            ram_wraddress_d = {slot_q, idx_q};
            ram_data_d      = step_data & STEP_MASK;
            idx_d           = idx_q + 1'b1;
            step_count_d    = idx_q + 1'b1;
          end
          if (commit || (accept && (idx_q == MAX_STEPS_M1))) begin
            state_d = S_TERM;
          end
        end
      end

      S_TERM: begin
        // a full slot with the source still offering steps is the overflow case
        if (step_valid && (idx_q == MAX_STEPS)) begin
          overflow_d = 1'b1;
        end
        ram_wren_d      = 1'b1;
        ram_wraddress_d = {slot_q, idx_q};
        ram_data_d      = {1'b1, {(DATA_W-1-SLOT_W){1'b0}}, step_count_q};
        state_d         = S_DONE;
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    step_ready_d = (state_d == S_RECORD) && (idx_d < MAX_STEPS);
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      state_q         <= S_IDLE;
      slot_q          <= '0;
      idx_q           <= '0;
      step_count_q    <= '0;
      step_ready_q    <= 1'b0;
      ram_wren_q      <= 1'b0;
      ram_wraddress_q <= '0;
      ram_data_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      slot_q          <= slot_d;
      idx_q           <= idx_d;
      step_count_q    <= step_count_d;
      step_ready_q    <= step_ready_d;
      ram_wren_q      <= ram_wren_d;
      ram_wraddress_q <= ram_wraddress_d;
      ram_data_q      <= ram_data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      overflow_q      <= overflow_d;
    end
  end

  assign step_ready    = step_ready_q;
  assign ram_wren      = ram_wren_q;
  assign ram_wraddress = ram_wraddress_q;
  assign ram_data      = ram_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign step_count    = step_count_q;
  assign overflow      = overflow_q;

endmodule
